lcd_bus_driver: RTL

- Parametrised successor to the team's single-byte HD44780 write engine.
- Accepts one command or data byte per start/ready handshake and drives it onto a character-LCD bus in either 8-bit or 4-bit mode.
- All timings are set by parameters. The post-write hold is chosen automatically: short for normal commands, long for clear/home.
- Sits between the LCD init/print sequencer and the board LCD pins.

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_timer.sv | 26 ++
 rtl/lcd_bus_driver.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and command constants for the character-LCD bus driver.
// Imported by the driver top and its timer.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE_HI,
    GAP,
    PULSE_LO2,
    HOLD
  } state_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Home ignores bit 0, so 0x03 is also a home command.
  function automatic logic is_long_cmd(
    input logic       rs,
    input logic [7:0] b
  );
    return !rs &&
      (b == CMD_CLEAR || b == CMD_HOME ||
       b == (CMD_HOME | 8'h01));
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter with zero flag.
// Shared by every timed state of the driver.
module lcd_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 bus write engine, 8-bit or 4-bit mode.
// One byte per start/ready handshake, auto-selected post-write hold.
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int BUS_WIDTH   = 8,
  parameter int SETUP_CYC   = 100,
  parameter int PULSE_CYC   = 100,
  parameter int GAP_CYC     = 100,
  parameter int DELAY_SHORT = 2_500,
  parameter int DELAY_LONG  = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       rs_in,
  input  logic       nibble_only,
  input  logic       start,
  output logic       ready,
  output logic       done,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_ON,
  output logic       LCD_BLON
);

  localparam bit NARROW = (BUS_WIDTH == 4);

  localparam int M1 =
    (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int M2 =
    (GAP_CYC > DELAY_SHORT) ? GAP_CYC : DELAY_SHORT;
  localparam int M3 = (M1 > M2) ? M1 : M2;
  localparam int T_MAX =
    (M3 > DELAY_LONG) ? M3 : DELAY_LONG;
  localparam int CW = $clog2(T_MAX) + 1;

  // Timer counts down to zero, so loads are N-1.
  localparam logic [CW-1:0] L_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] L_PULSE = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] L_GAP   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] L_SHORT = CW'(DELAY_SHORT - 1);
  localparam logic [CW-1:0] L_LONG  = CW'(DELAY_LONG - 1);

  state_t        state, state_n;
  logic          load;
  logic [CW-1:0] load_val;
  logic          zero;
  logic          accept;
  logic [3:0]    lo_nib;
  logic          nib_q;
  logic          long_q;

  lcd_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    load_val = '0;
    unique case (state)
      IDLE: if (start) begin
        state_n  = SETUP;
        load     = 1'b1;
        load_val = L_SETUP;
      end
      SETUP: if (zero) begin
        state_n  = PULSE_HI;
        load     = 1'b1;
        load_val = L_PULSE;
      end
      PULSE_HI: if (zero) begin
        load = 1'b1;
        if (NARROW && !nib_q) begin
          state_n  = GAP;
          load_val = L_GAP;
        end else begin
          state_n  = HOLD;
          load_val = long_q ? L_LONG : L_SHORT;
        end
      end
      GAP: if (zero) begin
        state_n  = PULSE_LO2;
        load     = 1'b1;
        load_val = L_PULSE;
      end
      PULSE_LO2: if (zero) begin
        state_n  = HOLD;
        load     = 1'b1;
        load_val = long_q ? L_LONG : L_SHORT;
      end
      HOLD: if (zero)
        state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done     <= 1'b0;
      LCD_DATA <= '0;
      LCD_RS   <= 1'b0;
      lo_nib   <= '0;
      nib_q    <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      done <= (state == HOLD) && zero;
      if (accept) begin
        lo_nib   <= data_in[3:0];
        LCD_RS   <= rs_in;
        nib_q    <= NARROW && nibble_only;
        long_q   <= is_long_cmd(rs_in, data_in);
        LCD_DATA <= NARROW ?
          {data_in[7:4], 4'h0} : data_in;
      end else if (state == PULSE_HI && state_n == GAP) begin
        LCD_DATA <= {lo_nib, 4'h0};
      end
    end
  end

  always_comb begin
    ready  = (state == IDLE);
    LCD_EN = (state == PULSE_HI) ||
             (state == PULSE_LO2);
  end

  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;

endmodule
